keypad_entry_ctrl: RTL and testbench

- Sequences numeric entry from the PS/2 keyboard datapath: consumes the decoder's key events, manages a 4-digit right-aligned entry buffer and drives the four seven-segment digit inputs.
- On Enter, converts the BCD buffer to binary over 4 cycles and presents the result with a one-cycle valid pulse.
- Sits between the keyboard decoder (key_valid / last_change / key_down) and seven_segment / downstream logic.

---
 rtl/keypad_entry_ctrl_if.sv | 26 ++
 rtl/keypad_entry_ctrl.sv | 142 ++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_ctrl_if.sv
// Key-event inputs and display/result outputs of the keypad entry controller.
interface keypad_entry_ctrl_if;
  logic         en;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic [3:0]   digit_0;
  logic [3:0]   digit_1;
  logic [3:0]   digit_2;
  logic [3:0]   digit_3;
  logic [13:0]  value;
  logic         value_valid;
  logic [2:0]   count;
  logic         busy;
  logic         err;

  modport master (
    output en, key_valid, last_change, key_down,
    input  digit_0, digit_1, digit_2, digit_3, value, value_valid, count, busy, err
  );

  modport slave (
    input  en, key_valid, last_change, key_down,
    output digit_0, digit_1, digit_2, digit_3, value, value_valid, count, busy, err
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Numeric keypad entry: right-aligned 4-digit buffer driving seven-segment
// digits, with a 4-cycle BCD-to-binary conversion on Enter.
module keypad_entry_ctrl #(
  parameter int unsigned DIGITS     = 4,
  parameter logic [8:0]  CODE_ENTER = 9'h05A,
  parameter logic [8:0]  CODE_BKSP  = 9'h066,
  parameter logic [8:0]  CODE_ESC   = 9'h076
) (
  input logic                clk,
  input logic                rst,
  keypad_entry_ctrl_if.slave kp
);
  localparam logic [3:0] DASH  = 4'd10;
  localparam logic [3:0] BLANK = 4'd15;

  typedef enum logic [1:0] {IDLE, ENTRY, CONVERT, DONE} state_t;

  state_t      state;
  logic [3:0]  dig [DIGITS];
  logic [2:0]  cnt;
  logic [1:0]  idx;
  logic [13:0] acc;
  logic [13:0] value_r;
  logic        value_valid_r;
  logic        busy_r;
  logic        err_r;

  logic        press;
  logic        is_digit;
  logic        is_enter;
  logic        is_bksp;
  logic        is_esc;
  logic [3:0]  key_digit;
  logic [3:0]  cur;
  logic [13:0] acc_next;

  always_comb begin
    press     = kp.key_valid && kp.key_down[kp.last_change] && kp.en;
    is_digit  = 1'b0;
    key_digit = '0;
    if (!kp.last_change[8]) begin
      is_digit = 1'b1;
      case (kp.last_change[7:0])
        8'h70:   key_digit = 4'd0;
        8'h69:   key_digit = 4'd1;
        8'h72:   key_digit = 4'd2;
        8'h7A:   key_digit = 4'd3;
        8'h6B:   key_digit = 4'd4;
        8'h73:   key_digit = 4'd5;
        8'h74:   key_digit = 4'd6;
        8'h6C:   key_digit = 4'd7;
        8'h75:   key_digit = 4'd8;
        8'h7D:   key_digit = 4'd9;
        default: is_digit  = 1'b0;
      endcase
    end
    is_enter = (kp.last_change == CODE_ENTER);
    is_bksp  = (kp.last_change == CODE_BKSP);
    is_esc   = (kp.last_change == CODE_ESC);
    // Blank positions are leading empties of a short entry; they add nothing.
    cur      = dig[idx];
    acc_next = (cur == BLANK) ? acc : (acc * 14'd10) + 14'(cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int unsigned i = 0; i < DIGITS; i++) dig[i] <= DASH;
      cnt           <= '0;
      idx           <= '0;
      acc           <= '0;
      value_r       <= '0;
      value_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (press && is_digit) begin
            state  <= ENTRY;
            dig[0] <= key_digit;
            for (int unsigned i = 1; i < DIGITS; i++) dig[i] <= BLANK;
            cnt    <= 3'd1;
          end else if (press && is_esc && state == DONE) begin
            state <= IDLE;
            for (int unsigned i = 0; i < DIGITS; i++) dig[i] <= DASH;
            cnt   <= '0;
          end
        end
        ENTRY: begin
          if (press) begin
            if (is_digit) begin
              if (cnt == 3'(DIGITS)) begin
                err_r <= 1'b1;
              end else begin
                for (int unsigned i = DIGITS - 1; i > 0; i--) dig[i] <= dig[i-1];
                dig[0] <= key_digit;
                cnt    <= cnt + 3'd1;
              end
            end else if (is_bksp && cnt > 3'd1) begin
              for (int unsigned i = 0; i < DIGITS - 1; i++) dig[i] <= dig[i+1];
              dig[DIGITS-1] <= BLANK;
              cnt           <= cnt - 3'd1;
            end else if (is_bksp || is_esc) begin
              state <= IDLE;
              for (int unsigned i = 0; i < DIGITS; i++) dig[i] <= DASH;
              cnt   <= '0;
            end else if (is_enter) begin
              state  <= CONVERT;
              acc    <= '0;
              idx    <= 2'(DIGITS - 1);
              busy_r <= 1'b1;
            end
          end
        end
        CONVERT: begin
          acc <= acc_next;
          idx <= idx - 2'd1;
          if (idx == 2'd0) begin
            value_r       <= acc_next;
            value_valid_r <= 1'b1;
            busy_r        <= 1'b0;
            state         <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kp.digit_0     = dig[0];
  assign kp.digit_1     = dig[1];
  assign kp.digit_2     = dig[2];
  assign kp.digit_3     = dig[3];
  assign kp.count       = cnt;
  assign kp.value       = value_r;
  assign kp.value_valid = value_valid_r;
  assign kp.busy        = busy_r;
  assign kp.err         = err_r;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus random key streams
// checked against a queue-based model of the entry buffer.
module tb_keypad_entry_ctrl;
  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_BKSP  = 9'h066;
  localparam logic [8:0] K_ESC   = 9'h076;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_entry_ctrl_if kif();
  keypad_entry_ctrl dut (.clk(clk), .rst(rst), .kp(kif));

  logic [8:0] kc [10] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                          9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};

  // model: 0 idle, 1 entry, 2 convert, 3 done
  int mstate;
  int q[$];
  int mval;
  bit exp_err;
  int n_total = 0;
  int n_pass  = 0;

  function automatic int code_digit(input logic [8:0] c);
    for (int i = 0; i < 10; i++) if (kc[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [15:0] exp_disp();
    logic [15:0] r;
    if (mstate == 0) return 16'hAAAA;
    r = 16'hFFFF;
    for (int i = 0; i < q.size(); i++) r[i*4 +: 4] = 4'(q[q.size()-1-i]);
    return r;
  endfunction

  function automatic int exp_value();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic logic [15:0] obs_disp();
    return {kif.digit_3, kif.digit_2, kif.digit_1, kif.digit_0};
  endfunction

  task automatic model_reset();
    mstate = 0;
    q = {};
    mval = 0;
  endtask

  task automatic apply_key(input logic [8:0] code, input bit down, input bit enable);
    int d;
    kif.last_change = code;
    for (int i = 0; i < 16; i++) kif.key_down[i*32 +: 32] = $urandom;
    kif.key_down[code] = down;
    kif.en = enable;
    kif.key_valid = 1'b1;
    @(posedge clk); #1;
    kif.key_valid = 1'b0;
    kif.en = 1'b1;
    exp_err = 1'b0;
    if (enable && down) begin
      d = code_digit(code);
      case (mstate)
        0: if (d >= 0) begin q = {d}; mstate = 1; end
        1: begin
          if (d >= 0) begin
            if (q.size() < 4) q.push_back(d); else exp_err = 1'b1;
          end else if (code == K_BKSP) begin
            if (q.size() > 1) void'(q.pop_back());
            else begin q = {}; mstate = 0; end
          end else if (code == K_ESC) begin
            q = {}; mstate = 0;
          end else if (code == K_ENTER) begin
            mstate = 2;
          end
        end
        3: begin
          if (d >= 0) begin q = {d}; mstate = 1; end
          else if (code == K_ESC) begin q = {}; mstate = 0; end
        end
        default: ;
      endcase
    end
    n_total += 6;
    if (obs_disp() !== exp_disp())
      $display("FAIL key_disp code=%h: got %h expected %h", code, obs_disp(), exp_disp());
    else n_pass++;
    if (kif.count !== 3'(q.size()))
      $display("FAIL key_count code=%h: got %0d expected %0d", code, kif.count, q.size());
    else n_pass++;
    if (kif.err !== exp_err)
      $display("FAIL key_err code=%h: got %b expected %b", code, kif.err, exp_err);
    else n_pass++;
    if (kif.value !== 14'(mval))
      $display("FAIL key_value code=%h: got %0d expected %0d", code, kif.value, mval);
    else n_pass++;
    if (kif.busy !== (mstate == 2))
      $display("FAIL key_busy code=%h: got %b expected %b", code, kif.busy, mstate == 2);
    else n_pass++;
    if (kif.value_valid !== 1'b0)
      $display("FAIL key_vvalid code=%h: got %b expected 0", code, kif.value_valid);
    else n_pass++;
  endtask

  // Called right after the Enter edge; optionally throws key presses at it.
  task automatic run_convert(input bit noise);
    int ev;
    ev = exp_value();
    for (int k = 1; k <= 4; k++) begin
      if (noise) begin
        kif.last_change = kc[$urandom_range(9)];
        kif.key_down = '0;
        kif.key_down[kif.last_change] = 1'b1;
        kif.key_valid = 1'b1;
      end
      @(posedge clk); #1;
      kif.key_valid = 1'b0;
      n_total++;
      if (k < 4) begin
        if (kif.busy !== 1'b1 || kif.value_valid !== 1'b0)
          $display("FAIL conv_busy cyc%0d: got busy=%b vv=%b expected busy=1 vv=0", k, kif.busy, kif.value_valid);
        else n_pass++;
      end else begin
        if (kif.value_valid !== 1'b1 || kif.value !== 14'(ev) || kif.busy !== 1'b0)
          $display("FAIL conv_done: got vv=%b value=%0d busy=%b expected vv=1 value=%0d busy=0",
                   kif.value_valid, kif.value, kif.busy, ev);
        else n_pass++;
      end
    end
    mval = ev;
    mstate = 3;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (kif.value_valid !== 1'b0 || kif.busy !== 1'b0 || obs_disp() !== exp_disp() || kif.value !== 14'(mval))
        $display("FAIL idle_steady: got vv=%b busy=%b disp=%h value=%0d expected vv=0 busy=0 disp=%h value=%0d",
                 kif.value_valid, kif.busy, obs_disp(), kif.value, exp_disp(), mval);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    n_total++;
    if (obs_disp() !== 16'hAAAA || kif.count !== 3'd0 || kif.value !== 14'd0 ||
        kif.value_valid !== 1'b0 || kif.busy !== 1'b0 || kif.err !== 1'b0)
      $display("FAIL reset_state: got disp=%h cnt=%0d val=%0d vv=%b busy=%b err=%b expected disp=aaaa others 0",
               obs_disp(), kif.count, kif.value, kif.value_valid, kif.busy, kif.err);
    else n_pass++;
  endtask

  task automatic test_basic_entry();
    apply_key(kc[7], 1, 1);
    apply_key(kc[4], 1, 1);
    n_total++;
    if (obs_disp() !== 16'hFF74 || kif.count !== 3'd2)
      $display("FAIL basic_digits: got %h cnt=%0d expected ff74 cnt=2", obs_disp(), kif.count);
    else n_pass++;
    apply_key(K_ENTER, 1, 1);
    run_convert(0);
    n_total++;
    if (kif.value !== 14'd74)
      $display("FAIL basic_value: got %0d expected 74", kif.value);
    else n_pass++;
    idle_cycles(2);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) apply_key(kc[9], 1, 1);
    apply_key(kc[5], 1, 1);
    n_total++;
    if (obs_disp() !== 16'h9999 || kif.err !== 1'b1)
      $display("FAIL full_reject: got disp=%h err=%b expected 9999 err=1", obs_disp(), kif.err);
    else n_pass++;
    idle_cycles(1);
    apply_key(K_ENTER, 1, 1);
    run_convert(0);
    n_total++;
    if (kif.value !== 14'd9999)
      $display("FAIL full_value: got %0d expected 9999", kif.value);
    else n_pass++;
  endtask

  task automatic test_backspace();
    apply_key(K_ESC, 1, 1);
    apply_key(kc[1], 1, 1);
    apply_key(kc[2], 1, 1);
    apply_key(kc[3], 1, 1);
    apply_key(K_BKSP, 1, 1);
    n_total++;
    if (obs_disp() !== 16'hFF12 || kif.count !== 3'd2)
      $display("FAIL bksp_shift: got %h cnt=%0d expected ff12 cnt=2", obs_disp(), kif.count);
    else n_pass++;
    apply_key(K_BKSP, 1, 1);
    apply_key(K_BKSP, 1, 1);
    n_total++;
    if (obs_disp() !== 16'hAAAA || kif.count !== 3'd0)
      $display("FAIL bksp_idle: got %h cnt=%0d expected aaaa cnt=0", obs_disp(), kif.count);
    else n_pass++;
    apply_key(K_ENTER, 1, 1);
    idle_cycles(5);
  endtask

  task automatic test_dropped_events();
    apply_key(kc[5], 1, 0);
    apply_key(kc[5], 0, 1);
    apply_key(K_ESC, 0, 1);
    apply_key(kc[2], 1, 1);
    apply_key(kc[5], 1, 0);
    apply_key(kc[8], 0, 1);
    apply_key(K_BKSP, 0, 1);
    apply_key(K_ENTER, 1, 0);
    n_total++;
    if (obs_disp() !== 16'hFFF2 || kif.count !== 3'd1 || kif.busy !== 1'b0)
      $display("FAIL drop_events: got %h cnt=%0d busy=%b expected fff2 cnt=1 busy=0", obs_disp(), kif.count, kif.busy);
    else n_pass++;
    apply_key(K_ESC, 1, 1);
  endtask

  task automatic test_convert_drop();
    apply_key(kc[8], 1, 1);
    apply_key(K_ENTER, 1, 1);
    run_convert(1);
    n_total++;
    if (kif.value !== 14'd8 || obs_disp() !== 16'hFFF8)
      $display("FAIL conv_drop: got value=%0d disp=%h expected 8 fff8", kif.value, obs_disp());
    else n_pass++;
    apply_key(kc[3], 1, 1);
    n_total++;
    if (kif.digit_0 !== 4'd3 || kif.value !== 14'd8 || kif.count !== 3'd1)
      $display("FAIL done_restart: got d0=%0d value=%0d cnt=%0d expected 3 8 1", kif.digit_0, kif.value, kif.count);
    else n_pass++;
    apply_key(K_ESC, 1, 1);
    n_total++;
    if (obs_disp() !== 16'hAAAA)
      $display("FAIL esc_dash: got %h expected aaaa", obs_disp());
    else n_pass++;
  endtask

  task automatic test_reset_mid_convert();
    apply_key(kc[6], 1, 1);
    apply_key(kc[0], 1, 1);
    apply_key(K_ENTER, 1, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    n_total++;
    if (obs_disp() !== 16'hAAAA || kif.value !== 14'd0 || kif.value_valid !== 1'b0 ||
        kif.busy !== 1'b0 || kif.count !== 3'd0)
      $display("FAIL reset_mid: got disp=%h val=%0d vv=%b busy=%b cnt=%0d expected aaaa 0 0 0 0",
               obs_disp(), kif.value, kif.value_valid, kif.busy, kif.count);
    else n_pass++;
    idle_cycles(5);
  endtask

  task automatic test_random();
    int r;
    logic [8:0] code;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(99);
      if (r < 40)      apply_key(kc[$urandom_range(9)], 1, 1);
      else if (r < 52) apply_key(K_ENTER, 1, 1);
      else if (r < 64) apply_key(K_BKSP, 1, 1);
      else if (r < 70) apply_key(K_ESC, 1, 1);
      else if (r < 80) begin
        code = 9'($urandom);
        apply_key(code, 1, 1);
      end
      else if (r < 90) apply_key(kc[$urandom_range(9)], 0, 1);
      else             apply_key(kc[$urandom_range(9)], 1, 0);
      if (mstate == 2) run_convert(1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    kif.en = 1'b1;
    kif.key_valid = 1'b0;
    kif.last_change = '0;
    kif.key_down = '0;
    model_reset();
    test_reset();
    test_basic_entry();
    test_overflow();
    test_backspace();
    test_dropped_events();
    test_convert_drop();
    test_reset_mid_convert();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
